sample_readout: RTL
===================

// Module: sample_readout
// PURPOSE
// - Read-side counterpart to the ADC capture path: streams a block of stored
//   samples from sample memory to the MCU-link transmitter.
// - On a start pulse, walks memory from start_adr for count words and issues
//   synchronous RAM reads. Each word goes out on a valid/ready interface.
// - Sits between the sample RAM read port and the SPI transmit shifter.
// PARAMETERS
// - ADDR_W   16  sample memory address width (matches capture-side address)
// - DATA_W   16  sample word width; must be <= 16
// - RAM_LAT  1   RAM read latency, cycles from rd_en to valid rd_data (>=1)
// PORTS
// - clk        in   1       system clock, all logic on posedge
// - reset      in   1       asynchronous, active-high reset
// - start      in   1       1-cycle request; sampled only in IDLE
// - start_adr  in   ADDR_W  first address to read; latched on accepted start
// - count      in   ADDR_W  words to read; latched on accepted start
// - rd_en      out  1       RAM read strobe, 1 cycle per word
// - rd_adr     out  ADDR_W  RAM read address
// - rd_data    in   DATA_W  RAM read data, valid RAM_LAT cycles after rd_en
// - tx_data    out  DATA_W  word to transmitter
// - tx_valid   out  1       tx_data valid; held until tx_ready
// - tx_ready   in   1       transmitter accepts word when valid&&ready
// - tx_last    out  1       qualifies the final word of the block
// - busy       out  1       high from accepted start until done
// - done       out  1       1-cycle pulse when the block completes
// BEHAVIOUR
// - Reset (async): all outputs 0, FSM to IDLE, latched adr/count/checksum to 0.
// - FSM states:
//   - IDLE: start=1 and count!=0 -> ISSUE. start=1 and count==0 -> FIN.
//   - ISSUE: rd_en=1 for 1 cycle -> WAIT.
//   - WAIT: RAM_LAT cycles, then capture rd_data into tx_data -> SEND.
//   - SEND: tx_valid=1; on tx_ready, decrement remaining.
//     - Remaining !=0: adr+1 -> ISSUE.
//     - Remaining ==0: -> FIN.
//   - FIN: done=1 and busy=0 for 1 cycle -> IDLE.
// - Latency: start accepted at edge k; rd_en high in cycle k+1; first tx_valid
//   in cycle k+2+RAM_LAT.
// - Throughput: 1 word per RAM_LAT+2 cycles with no backpressure. No prefetch.
// - Backpressure: while tx_valid && !tx_ready, tx_data, tx_last and rd_adr are
//   stable and rd_en stays 0.
// - Address wraps modulo 2^ADDR_W (0xFFFF+1 -> 0x0000); count is not clipped.
// - start while busy is ignored; start_adr/count changes mid-block have no
//   effect.
// - Reset mid-block aborts immediately; no done pulse; next block needs start.
// CONFIGURATION
// - READOUT_CHECKSUM_EN defined: a 16-bit running sum (mod 2^16) of every sent
//   sample, zero-extended, is kept.
//   - After the last sample, one extra word goes out: ISSUE/WAIT skipped,
//     SEND with tx_data = checksum.
//   - tx_last moves to the checksum word. count==0 sends checksum 0x0000.
// - Undefined: no checksum logic. tx_last is on the final sample.
// STRUCTURE
// - Package readout_pkg:
//   - state enum (IDLE, ISSUE, WAIT, SEND, FIN).
//   - ADDR_W/DATA_W defaults.
//   - CKSUM_W=16 constant.
// - Sub-module readout_addr_gen: loadable ADDR_W up-counter (load on start,
//   inc on handshake) plus remaining-count down-counter with zero flag.
// TESTING
// - start_adr=0x0010, count=4, tx_ready=1:
//   - rd_adr 0x0010..0x0013; tx_data = mem[0x10..0x13].
//   - tx_last only on word 4; done 1 cycle after final handshake.
// - start_adr=0xFFFE, count=4 -> rd_adr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
// - tx_ready low 5 cycles during word 2 -> tx_data/tx_valid/rd_adr stable and
//   rd_en=0 throughout; word 3 read only after the handshake.
// - count=0 start -> busy 0, done pulse at k+1, tx_valid never asserted.
// - start pulsed during busy -> ignored.
//   - reset asserted mid-word-2 -> all outputs 0 at once.
//   - after release, idle until new start.
// - READOUT_CHECKSUM_EN, mem = 0x0001, 0x0002, 0xFFFF, count=3 -> 4 words out;
//   4th = 0x0002 with tx_last=1.

Source files
------------

// File: rtl/readout_pkg.sv
// Shared types and constants for the sample readout path.
package readout_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    SEND,
    FIN
  } state_t;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int CKSUM_W    = 16;

endpackage

// File: rtl/readout_addr_gen.sv
// Read address up-counter and remaining-word down-counter for one readout block.
// rem holds the number of words still to send after the current one.
module readout_addr_gen
  import readout_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_adr,
  input  logic [ADDR_W-1:0] load_cnt,
  output logic [ADDR_W-1:0] adr,
  output logic              rem_zero
);

  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adr_q <= '0;
      rem_q <= '0;
    end else begin
      adr_q <= adr_d;
      rem_q <= rem_d;
    end
  end

  always_comb begin
    adr_d = adr_q;
    rem_d = rem_q;
    if (load) begin
      adr_d = load_adr;
      rem_d = load_cnt - ADDR_W'(1);
    end else if (step && (rem_q != '0)) begin
      adr_d = adr_q + ADDR_W'(1);
      rem_d = rem_q - ADDR_W'(1);
    end
  end

  assign adr      = adr_q;
  assign rem_zero = (rem_q == '0);

endmodule

// File: rtl/sample_readout.sv
// Streams a block of sample RAM words onto a valid/ready transmit link.
// Defining READOUT_CHECKSUM_EN appends a 16-bit sum word after the last sample.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | rd_en strobe for the current address
// WAIT  | RAM read latency, captures rd_data on the last cycle
// SEND  | tx_valid held until tx_ready
// FIN   | one-cycle done pulse, busy low
module sample_readout
  import readout_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_adr,
  input  logic [ADDR_W-1:0] count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_adr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic              busy,
  output logic              done
);

  localparam int LAT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  state_t            state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              start_acc;
  logic              hs;
  logic              sample_hs;
  logic              rem_zero;
  logic              last_flag;

`ifdef READOUT_CHECKSUM_EN
  localparam state_t ZERO_NEXT = SEND;
  logic [CKSUM_W-1:0] cksum_q, cksum_d;
  logic [CKSUM_W-1:0] cksum_sum;
  logic               phase_q, phase_d;

  assign cksum_sum = cksum_q + CKSUM_W'(tx_data_q);
  assign sample_hs = hs && !phase_q;
  assign last_flag = phase_q;
`else
  localparam state_t ZERO_NEXT = FIN;
  assign sample_hs = hs;
  assign last_flag = rem_zero;
`endif

  assign start_acc = (state_q == IDLE) && start;
  assign hs        = tx_valid && tx_ready;

  readout_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (start_acc),
    .step     (sample_hs),
    .load_adr (start_adr),
    .load_cnt (count),
    .adr      (rd_adr),
    .rem_zero (rem_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      tx_data_q <= '0;
`ifdef READOUT_CHECKSUM_EN
      cksum_q   <= '0;
      phase_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      tx_data_q <= tx_data_d;
`ifdef READOUT_CHECKSUM_EN
      cksum_q   <= cksum_d;
      phase_q   <= phase_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = (count != '0) ? ISSUE : ZERO_NEXT;
      ISSUE: state_d = WAIT;
      WAIT:  if (lat_q == '0) state_d = SEND;
      SEND: begin
        if (hs) begin
`ifdef READOUT_CHECKSUM_EN
          if (phase_q)       state_d = FIN;
          else if (rem_zero) state_d = SEND;
          else               state_d = ISSUE;
`else
          state_d = rem_zero ? FIN : ISSUE;
`endif
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lat_d     = lat_q;
    tx_data_d = tx_data_q;
    if (state_q == ISSUE) begin
      lat_d = LAT_W'(RAM_LAT - 1);
    end else if ((state_q == WAIT) && (lat_q != '0)) begin
      lat_d = lat_q - LAT_W'(1);
    end
    if ((state_q == WAIT) && (lat_q == '0)) begin
      tx_data_d = rd_data;
    end
`ifdef READOUT_CHECKSUM_EN
    cksum_d = cksum_q;
    phase_d = phase_q;
    // An empty block goes straight to the trailer word carrying a zero sum.
    if (start_acc) begin
      cksum_d = '0;
      phase_d = (count == '0);
      if (count == '0) tx_data_d = '0;
    end else if (sample_hs) begin
      cksum_d = cksum_sum;
      if (rem_zero) begin
        phase_d   = 1'b1;
        tx_data_d = DATA_W'(cksum_sum);
      end
    end else if (state_q == FIN) begin
      phase_d = 1'b0;
    end
`endif
  end

  always_comb begin
    rd_en    = 1'b0;
    tx_valid = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ISSUE: begin
        rd_en = 1'b1;
        busy  = 1'b1;
      end
      WAIT: busy = 1'b1;
      SEND: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  assign tx_data = tx_data_q;
  assign tx_last = tx_valid && last_flag;

endmodule
